// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin sequencer for the 6-bit I/O register bus.
// Each access takes one grant cycle and one strobe cycle; read data returns with a one-cycle rvalid.
module io_bus_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              re,
  output logic              we,
  output logic              busy
);
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                   state;
  logic                     last_gnt;
  logic                     gnt_id;
  logic                     gnt_sel;
  logic [1:0]               vld;
  logic [1:0]               req_we;
  logic [1:0][ADDR_W-1:0]   req_addr;
  logic [1:0][DATA_W-1:0]   req_wdata;
  logic [1:0]               ready;
  logic [1:0]               rvalid;
  logic [1:0][DATA_W-1:0]   rdata;

  assign vld       = {req1_valid, req0_valid};
  assign req_we    = {req1_we, req0_we};
  assign req_addr  = {req1_addr, req0_addr};
  assign req_wdata = {req1_wdata, req0_wdata};

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    gnt_sel = vld[1];
    if (vld == 2'b11) gnt_sel = ~last_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      addr     <= '0;
      data_in  <= '0;
      re       <= 1'b0;
      we       <= 1'b0;
      ready    <= '0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      ready  <= '0;
      rvalid <= '0;
      re     <= 1'b0;
      we     <= 1'b0;
      case (state)
        IDLE: begin
          if (|vld) begin
            addr           <= req_addr[gnt_sel];
            data_in        <= req_wdata[gnt_sel];
            re             <= ~req_we[gnt_sel];
            we             <= req_we[gnt_sel];
            ready[gnt_sel] <= 1'b1;
            gnt_id         <= gnt_sel;
            last_gnt       <= gnt_sel;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          // Device data is combinational off the strobe, so it is valid at this edge.
          if (re) begin
            rdata[gnt_id]  <= data_out;
            rvalid[gnt_id] <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state == ACCESS);
  assign req0_ready  = ready[0];
  assign req1_ready  = ready[1];
  assign req0_rvalid = rvalid[0];
  assign req1_rvalid = rvalid[1];
  assign req0_rdata  = rdata[0];
  assign req1_rdata  = rdata[1];
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with a small register-file device model.
module tb_io_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [5:0] req0_addr, req1_addr, addr;
  logic [7:0] req0_wdata, req1_wdata, req0_rdata, req1_rdata, data_in, data_out;
  logic       req0_ready, req1_ready, req0_rvalid, req1_rvalid, re, we, busy;

  int n_cmp = 0;
  int n_err = 0;
  logic both_hi = 1'b0;
  logic [7:0] mem [64];

  always #5 clk = ~clk;

  io_bus_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .addr(addr), .data_in(data_in), .data_out(data_out), .re(re), .we(we), .busy(busy)
  );

  // Device: addr 0/1 hold the switch bytes (sw = 0xA5C3), addr 4 drives the LEDs.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'hA5;
    mem[1] = 8'hC3;
  end
  always @(posedge clk) if (we) mem[addr] <= data_in;
  assign data_out = re ? mem[addr] : 8'h00;

  always @(negedge clk) if (re && we) both_hi = 1'b1;

  typedef struct {
    logic v0, w0; logic [5:0] a0; logic [7:0] d0;
    logic v1, w1; logic [5:0] a1; logic [7:0] d1;
    logic [1:0] rdy, rv; logic re, we, busy;
    logic [5:0] addr; logic [7:0] rd0, rd1;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic v0, logic w0, logic [5:0] a0, logic [7:0] d0,
                              logic v1, logic w1, logic [5:0] a1, logic [7:0] d1,
                              logic [1:0] rdy, logic [1:0] rv, logic xre, logic xwe, logic xbusy,
                              logic [5:0] xaddr, logic [7:0] rd0, logic [7:0] rd1);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.rdy = rdy; v.rv = rv; v.re = xre; v.we = xwe; v.busy = xbusy;
    v.addr = xaddr; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [5:0] a0, input logic [7:0] d0,
                       input logic v1, input logic w1, input logic [5:0] a1, input logic [7:0] d1);
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rdy_cnt;

  initial begin
    // read, write+readback, contention; each row = inputs and expected outputs of one cycle
    vecs[0]  = mk(1,0,6'h00,8'h00, 0,0,6'h00,8'h00, 2'b00,2'b00,0,0,0,6'h00,8'h00,8'h00);
    vecs[1]  = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 2'b01,2'b00,1,0,1,6'h00,8'h00,8'h00);
    vecs[2]  = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 2'b00,2'b01,0,0,0,6'h00,8'hA5,8'h00);
    vecs[3]  = mk(0,0,6'h00,8'h00, 1,1,6'h04,8'h3C, 2'b00,2'b00,0,0,0,6'h00,8'hA5,8'h00);
    vecs[4]  = mk(0,0,6'h00,8'h00, 1,0,6'h04,8'h00, 2'b10,2'b00,0,1,1,6'h04,8'hA5,8'h00);
    vecs[5]  = mk(0,0,6'h00,8'h00, 1,0,6'h04,8'h00, 2'b00,2'b00,0,0,0,6'h04,8'hA5,8'h00);
    vecs[6]  = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 2'b10,2'b00,1,0,1,6'h04,8'hA5,8'h00);
    vecs[7]  = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 2'b00,2'b10,0,0,0,6'h04,8'hA5,8'h3C);
    vecs[8]  = mk(1,0,6'h00,8'h00, 1,0,6'h01,8'h00, 2'b00,2'b00,0,0,0,6'h04,8'hA5,8'h3C);
    vecs[9]  = mk(1,0,6'h00,8'h00, 1,0,6'h01,8'h00, 2'b01,2'b00,1,0,1,6'h00,8'hA5,8'h3C);
    vecs[10] = mk(1,0,6'h00,8'h00, 1,0,6'h01,8'h00, 2'b00,2'b01,0,0,0,6'h00,8'hA5,8'h3C);
    vecs[11] = mk(1,0,6'h00,8'h00, 1,0,6'h01,8'h00, 2'b10,2'b00,1,0,1,6'h01,8'hA5,8'h3C);
    vecs[12] = mk(1,0,6'h00,8'h00, 1,0,6'h01,8'h00, 2'b00,2'b10,0,0,0,6'h01,8'hA5,8'hC3);
    vecs[13] = mk(1,0,6'h00,8'h00, 1,0,6'h01,8'h00, 2'b01,2'b00,1,0,1,6'h00,8'hA5,8'hC3);
    vecs[14] = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 2'b00,2'b01,0,0,0,6'h00,8'hA5,8'hC3);
    vecs[15] = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 2'b00,2'b00,0,0,0,6'h00,8'hA5,8'hC3);

    reset = 1'b1;
    drive(0,0,0,0, 0,0,0,0);
    step(); step();
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d ready", i),  {req1_ready, req0_ready},   vecs[i].rdy);
      chk($sformatf("v%0d rvalid", i), {req1_rvalid, req0_rvalid}, vecs[i].rv);
      chk($sformatf("v%0d re", i),     re,         vecs[i].re);
      chk($sformatf("v%0d we", i),     we,         vecs[i].we);
      chk($sformatf("v%0d busy", i),   busy,       vecs[i].busy);
      chk($sformatf("v%0d addr", i),   addr,       vecs[i].addr);
      chk($sformatf("v%0d rdata0", i), req0_rdata, vecs[i].rd0);
      chk($sformatf("v%0d rdata1", i), req1_rdata, vecs[i].rd1);
      step();
    end
    chk("led_value", mem[4], 8'h3C);

    // req0 streaming reads of addr 1 for 10 cycles
    rdy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1,0,6'h01,8'h00, 0,0,0,0);
      @(negedge clk);
      chk($sformatf("stream busy c%0d", i), busy, (i % 2));
      if (req0_ready) rdy_cnt++;
      step();
    end
    drive(0,0,0,0, 0,0,0,0);
    @(negedge clk);
    chk("stream grants", rdy_cnt, 5);
    chk("stream last rvalid", {req1_rvalid, req0_rvalid}, 2'b01);
    chk("stream rdata0", req0_rdata, 8'hC3);
    step();

    // reset landing on the ACCESS cycle of a req0 read (last_gnt is 0 here)
    drive(1,0,6'h01,8'h00, 0,0,0,0);
    step();
    drive(0,0,0,0, 0,0,0,0);
    reset = 1'b1;
    @(negedge clk);
    chk("pre-reset access", {re, busy, req1_ready, req0_ready}, 4'b1101);
    step();
    drive(1,0,6'h00,8'h00, 1,0,6'h01,8'h00);
    @(negedge clk);
    chk("post-reset outputs",
        {req1_ready, req0_ready, req1_rvalid, req0_rvalid, re, we, busy, addr, data_in, req0_rdata, req1_rdata},
        '0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("no grant under reset", {busy, req1_ready, req0_ready}, 3'b000);
    step();
    drive(0,0,0,0, 0,0,0,0);
    @(negedge clk);
    chk("tie after reset", {req1_ready, req0_ready}, 2'b01);
    chk("tie after reset addr", addr, 6'h00);
    step(); step();

    // long idle: bus quiet, address held
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d", i),
          {re, we, req1_ready, req0_ready, req1_rvalid, req0_rvalid, busy, addr}, {7'b0, 6'h00});
      step();
    end

    chk("re/we overlap", both_hi, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
